edf_arbiter: RTL and testbench

Earliest-deadline-first selection stage placed directly downstream of the per-line gateway cells in the EDF interrupt controller. It consumes each line's pending bit and absolute deadline, finds the pending line with the smallest deadline using a sequential one-line-per-cycle scan, and presents the winner on a valid/ready interface. On handshake it pulses a one-hot claim back to the winning gateway. A newly pending line preempts an unaccepted presentation.

---
 rtl/edf_ic_pkg.sv | 16 +
 rtl/edf_arbiter_if.sv | 31 +++
 rtl/edf_arbiter.sv | 119 +++++++++++
 tb/tb_edf_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/edf_ic_pkg.sv
// Shared types and default sizing for the EDF interrupt controller.
// The arbiter state enum lives here so other controller blocks can decode it.
package edf_ic_pkg;

  localparam int DefNrIrqs  = 4;
  localparam int DefTsWidth = 64;

  typedef logic [DefTsWidth-1:0] ts_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/edf_arbiter_if.sv
// Valid/ready bus carrying the selected interrupt id and its deadline.
// The arbiter is the master; the consumer (core side) is the slave.
interface edf_arbiter_if
  import edf_ic_pkg::*;
#(
  parameter int NrIrqs  = DefNrIrqs,
  parameter int TsWidth = DefTsWidth
);

  localparam int IdWidth = $clog2(NrIrqs);

  logic [IdWidth-1:0] irq_id;
  logic [TsWidth-1:0] irq_dl;
  logic               irq_valid;
  logic               irq_ready;

  modport master (
    output irq_id,
    output irq_dl,
    output irq_valid,
    input  irq_ready
  );

  modport slave (
    input  irq_id,
    input  irq_dl,
    input  irq_valid,
    output irq_ready
  );

endinterface

// File: rtl/edf_arbiter.sv
// Earliest-deadline-first selector: scans one line per cycle, presents the
// pending line with the smallest deadline and pulses a one-hot claim on handshake.
module edf_arbiter
  import edf_ic_pkg::*;
#(
  parameter int NrIrqs  = DefNrIrqs,
  parameter int TsWidth = DefTsWidth
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrIrqs-1:0]  ip_i,
  input  logic [TsWidth-1:0] dl_i [NrIrqs],
  output logic [NrIrqs-1:0]  claim_o,
  edf_arbiter_if.master      irq
);

  localparam int IdWidth = $clog2(NrIrqs);
  localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NrIrqs - 1);

  arb_state_e         state_q, state_d;
  logic [IdWidth-1:0] idx_q;
  logic [IdWidth-1:0] best_id_q;
  logic [TsWidth-1:0] best_dl_q;
  logic               best_vld_q;
  logic [NrIrqs-1:0]  ip_q;

  logic scan_hit;
  logic last_line;
  logic new_edge;

  // Strict compare: an equal deadline never displaces an earlier-scanned line.
  assign scan_hit  = ip_i[idx_q] && (!best_vld_q || (dl_i[idx_q] < best_dl_q));
  assign last_line = (idx_q == LastIdx);
  assign new_edge  = |(ip_i & ~ip_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      best_id_q  <= '0;
      best_dl_q  <= '0;
      best_vld_q <= 1'b0;
      ip_q       <= '0;
    end else begin
      ip_q <= ip_i;
      case (state_q)
        IDLE: begin
          idx_q      <= '0;
          best_vld_q <= 1'b0;
        end
        SCAN: begin
          if (scan_hit) begin
            best_id_q  <= idx_q;
            best_dl_q  <= dl_i[idx_q];
            best_vld_q <= 1'b1;
          end
          if (!last_line) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        PRESENT: begin
          // Preemption restarts the scan; a handshake takes priority over it.
          if (!irq.irq_ready && new_edge) begin
            idx_q      <= '0;
            best_vld_q <= 1'b0;
          end
        end
        default: begin
          idx_q      <= '0;
          best_vld_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|ip_i) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (last_line) begin
          state_d = (best_vld_q || scan_hit) ? PRESENT : IDLE;
        end
      end
      PRESENT: begin
        if (irq.irq_ready) begin
          state_d = IDLE;
        end else if (new_edge) begin
          state_d = SCAN;
        end else if (!ip_i[best_id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irq.irq_valid = (state_q == PRESENT);
    irq.irq_id    = best_id_q;
    irq.irq_dl    = best_dl_q;
    claim_o       = '0;
    if ((state_q == PRESENT) && irq.irq_ready) begin
      claim_o = NrIrqs'(1) << best_id_q;
    end
  end

endmodule

// File: tb/tb_edf_arbiter.sv
// Scoreboard bench for edf_arbiter: stimulus pushes the deadline-ordered winner,
// a negedge monitor pops and compares it against every handshake.
module tb_edf_arbiter;
  import edf_ic_pkg::*;

  localparam int N = 4;
  localparam int W = 64;

  typedef struct {
    int           id;
    logic [W-1:0] dl;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] ip;
  logic [W-1:0] dl [N];
  logic [N-1:0] claim;

  int   checks = 0;
  int   passes = 0;
  exp_t expQ[$];

  edf_arbiter_if #(.NrIrqs(N), .TsWidth(W)) irq_bus ();

  edf_arbiter #(.NrIrqs(N), .TsWidth(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .ip_i   (ip),
    .dl_i   (dl),
    .claim_o(claim),
    .irq    (irq_bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: smallest deadline among pending lines, lowest id among equals.
  function automatic int refWinner();
    logic [W-1:0] minDl;
    bit           any;
    minDl = '1;
    any   = 1'b0;
    for (int i = 0; i < N; i++)
      if (ip[i] && (!any || dl[i] < minDl)) begin
        minDl = dl[i];
        any   = 1'b1;
      end
    if (!any) return -1;
    for (int i = 0; i < N; i++)
      if (ip[i] && dl[i] == minDl) return i;
    return -1;
  endfunction

  task automatic waitValid(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (irq_bus.irq_valid) begin
        cyc = i;
        return;
      end
    end
  endtask

  // Accept every pending line in turn, clearing it as a gateway would on claim.
  task automatic drain(input int firstLat);
    int lat;
    int cyc;
    int w;
    lat = firstLat;
    while (ip != '0) begin
      w = refWinner();
      expQ.push_back('{w, dl[w]});
      waitValid(cyc);
      checkOutput("latency", W'(cyc), W'(lat));
      if (cyc == 0) begin
        ip = '0;
        break;
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      irq_bus.irq_ready = 1'b1;
      @(posedge clk);
      #1;
      irq_bus.irq_ready = 1'b0;
      ip[w] = 1'b0;
      lat = N + 1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] mask, input logic [W-1:0] d0,
                               input logic [W-1:0] d1, input logic [W-1:0] d2,
                               input logic [W-1:0] d3);
    dl[0] = d0;
    dl[1] = d1;
    dl[2] = d2;
    dl[3] = d3;
    ip    = mask;
    drain(N + 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && irq_bus.irq_valid && irq_bus.irq_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_handshake: got id %0d, expected no handshake", irq_bus.irq_id);
      end else begin
        e = expQ.pop_front();
        checkOutput("winner_id", W'(irq_bus.irq_id), W'(e.id));
        checkOutput("winner_dl", irq_bus.irq_dl, e.dl);
        checkOutput("claim", W'(claim), W'(1) << e.id);
      end
    end else begin
      checkOutput("claim_quiet", W'(claim), '0);
    end
  end

  initial begin
    int           cyc;
    logic [N-1:0] mask;
    rst = 1'b1;
    ip  = '0;
    for (int i = 0; i < N; i++) dl[i] = '0;
    irq_bus.irq_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", W'(irq_bus.irq_valid), '0);
    checkOutput("reset_id", W'(irq_bus.irq_id), '0);
    checkOutput("reset_dl", irq_bus.irq_dl, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single line");
    applyStimulus(4'b0100, 64'h0, 64'h0, 64'h50, 64'h0);
    $display("[TB] earliest deadline order");
    applyStimulus(4'b1111, 64'h20, 64'h30, 64'h10, 64'h40);
    $display("[TB] tie");
    applyStimulus(4'b1010, 64'h0, 64'h80, 64'h0, 64'h80);

    $display("[TB] preemption");
    dl[0] = 64'h100;
    ip    = 4'b0001;
    waitValid(cyc);
    checkOutput("preempt_first_latency", W'(cyc), W'(N + 1));
    dl[3] = 64'h10;
    ip[3] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("preempt_drop", W'(irq_bus.irq_valid), '0);
    drain(N);

    $display("[TB] withdrawal");
    dl[1] = 64'h5;
    ip    = 4'b0010;
    waitValid(cyc);
    checkOutput("withdraw_latency", W'(cyc), W'(N + 1));
    ip[1] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("withdraw_valid", W'(irq_bus.irq_valid), '0);
    end

    $display("[TB] ready without valid");
    irq_bus.irq_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    irq_bus.irq_ready = 1'b0;

    $display("[TB] reset mid-scan");
    dl[0] = 64'h7;
    dl[3] = 64'h3;
    ip    = 4'b1001;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    ip  = '0;
    @(posedge clk);
    #1;
    checkOutput("rst_scan_valid", W'(irq_bus.irq_valid), '0);
    checkOutput("rst_scan_id", W'(irq_bus.irq_id), '0);
    checkOutput("rst_scan_dl", irq_bus.irq_dl, '0);
    checkOutput("rst_scan_claim", W'(claim), '0);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("rst_scan_idle", W'(irq_bus.irq_valid), '0);
    end

    $display("[TB] randomized sets");
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1) dl[i] = W'($urandom_range(0, 7));
        else dl[i] = {$urandom, $urandom};
      mask = N'($urandom_range(1, (1 << N) - 1));
      ip   = mask;
      drain(N + 1);
    end

    checkOutput("queue_empty", W'(expQ.size()), '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
